// File: rtl/stack_calc.sv
// RPN stack calculator core: top of stack in a register, lower entries in a
// synchronous-read RAM, commands over valid/ready, iterative restoring divider.
module stack_calc #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int ARG_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [3:0]                 cmd_op,
  input  logic [ARG_W-1:0]           cmd_arg,
  output logic [DATA_W-1:0]          top,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       empty,
  output logic [1:0]                 err,
  output logic                       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam int CW = $clog2(DATA_W);

  localparam logic [3:0] OP_PUSH = 4'd0, OP_APPEND = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
                         OP_MUL = 4'd4, OP_DIVQ = 4'd5, OP_DIVR = 4'd6, OP_POP = 4'd7,
                         OP_DUP = 4'd8, OP_SWAP = 4'd9, OP_OVER = 4'd10, OP_NEG = 4'd11,
                         OP_CLEAR = 4'd12;
  localparam logic [1:0] ERR_OK = 2'd0, ERR_UNDER = 2'd1, ERR_OVER = 2'd2, ERR_DIV0 = 2'd3;

  typedef enum logic [1:0] {IDLE, FETCH, DIV, WRITE} state_t;
  state_t state, state_n;

  logic [DATA_W-1:0] t_r, t_n;
  logic [DW-1:0]     depth_r, depth_n;
  logic [1:0]        err_r, err_n;
  logic [3:0]        op_r;

  // One spare slot keeps every AW-bit address in range.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q, wd;
  logic [AW-1:0]     wa, ra;
  logic              we;

  logic [DATA_W-1:0] quo_r, dvs_r, rem_r, quo_n, rem_n;
  logic [DATA_W:0]   rem_sh;
  logic              ge;
  logic [CW-1:0]     cnt_r;
  logic              div_load, div_step;

  logic has1, has2, room;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  // cmd_ready depends only on the FSM state (high in IDLE); upstream must hold
  // cmd_valid and its payload until the transfer happens.
  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign top       = t_r;
  assign depth     = depth_r;
  assign empty     = (depth_r == '0);
  assign err       = err_r;

  assign has1 = (depth_r != '0);
  assign has2 = (depth_r >= DW'(2));
  assign room = (depth_r < DW'(DEPTH));
  // B always lives at depth-2; depth is frozen while a command is in flight.
  assign ra   = AW'(depth_r - DW'(2));

  assign rem_sh = {rem_r, quo_r[DATA_W-1]};
  assign ge     = (rem_sh >= {1'b0, dvs_r});
  assign rem_n  = ge ? DATA_W'(rem_sh - {1'b0, dvs_r}) : rem_sh[DATA_W-1:0];
  assign quo_n  = {quo_r[DATA_W-2:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    t_n      = t_r;
    depth_n  = depth_r;
    err_n    = err_r;
    we       = 1'b0;
    wa       = AW'(depth_r - DW'(1));
    wd       = t_r;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        err_n = ERR_OK;
        case (cmd_op)
          OP_PUSH:
            if (!room) err_n = ERR_OVER;
            else begin
              we = has1; t_n = DATA_W'(cmd_arg); depth_n = depth_r + DW'(1);
            end
          OP_APPEND:
            if (!has1) err_n = ERR_UNDER;
            else t_n = (t_r << ARG_W) | DATA_W'(cmd_arg);
          OP_ADD, OP_SUB, OP_MUL, OP_SWAP:
            if (!has2) err_n = ERR_UNDER;
            else begin state_n = FETCH; err_n = err_r; end
          OP_DIVQ, OP_DIVR:
            if (!has2) err_n = ERR_UNDER;
            else if (t_r == '0) err_n = ERR_DIV0;
            else begin state_n = FETCH; err_n = err_r; end
          OP_POP:
            if (!has1) err_n = ERR_UNDER;
            else begin state_n = FETCH; err_n = err_r; end
          OP_DUP:
            if (!has1) err_n = ERR_UNDER;
            else if (!room) err_n = ERR_OVER;
            else begin we = 1'b1; depth_n = depth_r + DW'(1); end
          OP_OVER:
            if (!has2) err_n = ERR_UNDER;
            else if (!room) err_n = ERR_OVER;
            else begin state_n = FETCH; err_n = err_r; end
          OP_NEG:
            if (!has1) err_n = ERR_UNDER;
            else t_n = -t_r;
          OP_CLEAR: begin t_n = '0; depth_n = '0; end
          default: ;
        endcase
      end
      FETCH: begin
        state_n = IDLE;
        err_n   = ERR_OK;
        depth_n = depth_r - DW'(1);
        case (op_r)
          OP_ADD: t_n = rd_q + t_r;
          OP_SUB: t_n = rd_q - t_r;
          OP_MUL: t_n = rd_q * t_r;
          OP_POP: t_n = has2 ? rd_q : '0;
          OP_OVER: begin
            we = 1'b1; t_n = rd_q; depth_n = depth_r + DW'(1);
          end
          OP_SWAP: begin state_n = WRITE; err_n = err_r; depth_n = depth_r; end
          default: begin
            state_n = DIV; err_n = err_r; depth_n = depth_r; div_load = 1'b1;
          end
        endcase
      end
      WRITE: begin
        // rd_q still holds B: the read address has not moved since FETCH.
        we      = 1'b1;
        wa      = ra;
        t_n     = rd_q;
        err_n   = ERR_OK;
        state_n = IDLE;
      end
      DIV: begin
        div_step = 1'b1;
        if (cnt_r == CW'(DATA_W - 1)) begin
          t_n     = (op_r == OP_DIVQ) ? quo_n : rem_n;
          depth_n = depth_r - DW'(1);
          err_n   = ERR_OK;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_r     <= '0;
      depth_r <= '0;
      err_r   <= ERR_OK;
      op_r    <= OP_PUSH;
      quo_r   <= '0;
      rem_r   <= '0;
      dvs_r   <= '0;
      cnt_r   <= '0;
    end else begin
      t_r     <= t_n;
      depth_r <= depth_n;
      err_r   <= err_n;
      if (cmd_valid && cmd_ready) op_r <= cmd_op;
      if (div_load) begin
        quo_r <= rd_q;
        rem_r <= '0;
        dvs_r <= t_r;
        cnt_r <= '0;
      end else if (div_step) begin
        quo_r <= quo_n;
        rem_r <= rem_n;
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd_q <= mem[ra];
  end
endmodule

// File: tb/tb_stack_calc.sv
// Directed bench for stack_calc: a queue-based stack model tracks the expected
// outputs cycle by cycle, with hand-computed literals pinning key results.
module tb_stack_calc;
  localparam int W = 32;
  localparam int DEPTH = 512;
  localparam int ARG_W = 8;
  localparam int DW = $clog2(DEPTH) + 1;

  localparam logic [3:0] OP_PUSH = 4'd0, OP_APPEND = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
                         OP_MUL = 4'd4, OP_DIVQ = 4'd5, OP_DIVR = 4'd6, OP_POP = 4'd7,
                         OP_DUP = 4'd8, OP_SWAP = 4'd9, OP_OVER = 4'd10, OP_NEG = 4'd11,
                         OP_CLEAR = 4'd12;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [ARG_W-1:0] cmd_arg;
  logic [W-1:0]     top;
  logic [DW-1:0]    depth;
  logic             empty;
  logic [1:0]       err;
  logic             busy;

  stack_calc #(.DATA_W(W), .DEPTH(DEPTH), .ARG_W(ARG_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .top(top), .depth(depth),
    .empty(empty), .err(err), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model state: stack bottom->top, last error code, busy expectation
  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_err = 2'd0;
  logic         exp_busy = 1'b0;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_top();
    if (exp_q.size() == 0) return '0;
    return exp_q[exp_q.size()-1];
  endfunction

  // per-cycle compare against the model
  always @(negedge clk) begin
    chk("cyc_top",   64'(top),       64'(exp_top()));
    chk("cyc_depth", 64'(depth),     64'(exp_q.size()));
    chk("cyc_empty", 64'(empty),     64'(exp_q.size() == 0));
    chk("cyc_err",   64'(err),       64'(exp_err));
    chk("cyc_busy",  64'(busy),      64'(exp_busy));
    chk("cyc_ready", 64'(cmd_ready), 64'(!exp_busy));
  end

  // driver: issue one command, apply its modelled effect at the expected edge
  task automatic cmd(input logic [3:0] op, input logic [7:0] arg);
    logic [W-1:0] q[$];
    logic [W-1:0] a, b, r;
    int n, lat;
    logic [1:0] e;
    q = exp_q; n = q.size(); lat = 0; e = 2'd0;
    case (op)
      OP_PUSH: if (n == DEPTH) e = 2'd2; else q.push_back(W'(arg));
      OP_APPEND: if (n < 1) e = 2'd1; else q[n-1] = (q[n-1] << ARG_W) | W'(arg);
      OP_ADD, OP_SUB, OP_MUL, OP_DIVQ, OP_DIVR:
        if (n < 2) e = 2'd1;
        else if ((op == OP_DIVQ || op == OP_DIVR) && q[n-1] == '0) e = 2'd3;
        else begin
          a = q.pop_back(); b = q.pop_back();
          case (op)
            OP_ADD:  r = b + a;
            OP_SUB:  r = b - a;
            OP_MUL:  r = b * a;
            OP_DIVQ: r = b / a;
            default: r = b % a;
          endcase
          q.push_back(r);
          lat = (op == OP_DIVQ || op == OP_DIVR) ? 1 + W : 1;
        end
      OP_POP: if (n < 1) e = 2'd1; else begin void'(q.pop_back()); lat = 1; end
      OP_DUP: if (n < 1) e = 2'd1; else if (n == DEPTH) e = 2'd2; else q.push_back(q[n-1]);
      OP_SWAP: if (n < 2) e = 2'd1; else begin a = q[n-1]; q[n-1] = q[n-2]; q[n-2] = a; lat = 2; end
      OP_OVER:
        if (n < 2) e = 2'd1;
        else if (n == DEPTH) e = 2'd2;
        else begin q.push_back(q[n-2]); lat = 1; end
      OP_NEG: if (n < 1) e = 2'd1; else q[n-1] = -q[n-1];
      OP_CLEAR: q.delete();
      default: ;
    endcase
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (lat > 0) begin
      exp_busy = 1'b1;
      repeat (lat) @(posedge clk);
      #1 exp_busy = 1'b0;
    end
    exp_q = q;
    exp_err = e;
  endtask

  task automatic lit(input string nm, input logic [63:0] t, input logic [63:0] d, input logic [63:0] e);
    @(negedge clk);
    chk({nm, "_top"}, 64'(top), t);
    chk({nm, "_depth"}, 64'(depth), d);
    chk({nm, "_err"}, 64'(err), e);
  endtask

  task automatic push_all_ones();
    cmd(OP_PUSH, 8'hFF);
    repeat (3) cmd(OP_APPEND, 8'hFF);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = 4'd0; cmd_arg = '0; rst = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_top", 64'(top), 64'h0);
    chk("rst_depth", 64'(depth), 64'h0);
    chk("rst_empty", 64'(empty), 64'h1);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_ready", 64'(cmd_ready), 64'h1);
    @(posedge clk); #1 rst = 1'b0;

    cmd(OP_PUSH, 8'h12); cmd(OP_APPEND, 8'h34); cmd(OP_APPEND, 8'h56);
    lit("append", 64'h123456, 1, 0);

    cmd(OP_CLEAR, 0); cmd(OP_PUSH, 7); cmd(OP_PUSH, 3); cmd(OP_SUB, 0);
    lit("sub", 4, 1, 0);
    cmd(OP_SUB, 0);
    lit("sub_under", 4, 1, 1);
    cmd(OP_PUSH, 5); cmd(OP_ADD, 0);
    lit("add", 9, 1, 0);

    cmd(OP_CLEAR, 0); cmd(OP_PUSH, 100); cmd(OP_PUSH, 7); cmd(OP_DIVR, 0);
    lit("divr", 2, 1, 0);
    cmd(OP_PUSH, 100); cmd(OP_PUSH, 7); cmd(OP_DIVQ, 0);
    lit("divq", 14, 2, 0);
    cmd(OP_CLEAR, 0); cmd(OP_PUSH, 100); cmd(OP_PUSH, 0); cmd(OP_DIVQ, 0);
    lit("div_zero", 0, 2, 3);
    cmd(4'd13, 8'hAA);
    lit("reserved", 0, 2, 0);

    cmd(OP_CLEAR, 0); push_all_ones(); cmd(OP_PUSH, 3); cmd(OP_DIVQ, 0);
    lit("divq_big", 64'h55555555, 1, 0);
    cmd(OP_PUSH, 8'h10); cmd(OP_DIVR, 0);
    lit("divr_big", 5, 1, 0);

    cmd(OP_CLEAR, 0); cmd(OP_APPEND, 1); cmd(OP_NEG, 0); cmd(OP_POP, 0);
    lit("empty_errs", 0, 0, 1);
    cmd(OP_PUSH, 9); cmd(OP_ADD, 0); cmd(OP_SWAP, 0); cmd(OP_OVER, 0); cmd(OP_DIVQ, 0);
    lit("one_errs", 9, 1, 1);

    cmd(OP_CLEAR, 0);
    for (int i = 0; i < DEPTH; i++) cmd(OP_PUSH, 8'(i));
    lit("full", 64'hFF, DEPTH, 0);
    cmd(OP_PUSH, 1);
    lit("push_ovf", 64'hFF, DEPTH, 2);
    cmd(OP_CLEAR, 0);
    for (int i = 0; i < DEPTH; i++) cmd(OP_PUSH, 8'(i));
    cmd(OP_DUP, 0);
    lit("dup_ovf", 64'hFF, DEPTH, 2);
    cmd(OP_POP, 0); cmd(OP_OVER, 0);
    lit("over_fill", 64'hFD, DEPTH, 0);
    cmd(OP_OVER, 0);
    lit("over_ovf", 64'hFD, DEPTH, 2);
    for (int i = 0; i < DEPTH; i++) cmd(OP_POP, 0);
    lit("drained", 0, 0, 0);
    cmd(OP_POP, 0);
    lit("pop_under", 0, 0, 1);

    cmd(OP_PUSH, 1); cmd(OP_PUSH, 2); cmd(OP_SWAP, 0); cmd(OP_OVER, 0);
    lit("swap_over", 2, 3, 0);
    cmd(OP_NEG, 0);
    lit("neg", 64'hFFFFFFFE, 3, 0);
    cmd(OP_POP, 0);
    lit("pop_mid", 1, 2, 0);
    cmd(OP_POP, 0);
    lit("pop_bottom", 2, 1, 0);
    cmd(OP_DUP, 0);
    lit("dup", 2, 2, 0);

    cmd(OP_CLEAR, 0); push_all_ones(); cmd(OP_PUSH, 2); cmd(OP_MUL, 0);
    lit("mul_wrap", 64'hFFFFFFFE, 1, 0);

    // reset in the middle of a division, with a held command that must not be taken
    cmd(OP_CLEAR, 0); cmd(OP_PUSH, 100); cmd(OP_PUSH, 7);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_DIVQ;
    @(posedge clk); #1;
    exp_busy = 1'b1;
    cmd_op = OP_PUSH; cmd_arg = 8'hEE;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1; cmd_valid = 1'b0;
    exp_q.delete(); exp_err = 2'd0; exp_busy = 1'b0;
    #2;
    chk("midrst_top", 64'(top), 64'h0);
    chk("midrst_depth", 64'(depth), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    cmd(OP_PUSH, 8'h5A);
    lit("after_rst", 64'h5A, 1, 0);

    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
